// File: rtl/hazard_scoreboard_if.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard_if
//  Bundles the ID-stage request signals and the hazard-control responses
//  exchanged between the pipeline and the hazard scoreboard.
//  master : pipeline side (drives ID-stage info, receives stall/flush controls)
//  slave  : scoreboard side
//  Signals
//   valid_ID, rs1_ID, rs2_ID, rs1_used, rs2_used, rd_ID, RW_ID, MemRead_ID,
//   mc_ID, mc_lat_ID, Branch_ID, redirect_MEM        pipeline -> scoreboard
//   PCWrite, stall_IF_ID, flush_IF_ID, flush_ID_EX, flush_EX_MEM, mc_cancel,
//   stall_cycles                                      scoreboard -> pipeline
// ----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
   parameter int unsigned AW        = 5,
   parameter int unsigned MC_MAXLAT = 31
);
   localparam int unsigned CW = $clog2(MC_MAXLAT + 2);

   logic          valid_ID;
   logic [AW-1:0] rs1_ID;
   logic [AW-1:0] rs2_ID;
   logic          rs1_used;
   logic          rs2_used;
   logic [AW-1:0] rd_ID;
   logic          RW_ID;
   logic          MemRead_ID;
   logic          mc_ID;
   logic [CW-1:0] mc_lat_ID;
   logic          Branch_ID;
   logic          redirect_MEM;

   logic          PCWrite;
   logic          stall_IF_ID;
   logic          flush_IF_ID;
   logic          flush_ID_EX;
   logic          flush_EX_MEM;
   logic          mc_cancel;
   logic [31:0]   stall_cycles;

   modport master (
      output valid_ID, rs1_ID, rs2_ID, rs1_used, rs2_used, rd_ID, RW_ID,
             MemRead_ID, mc_ID, mc_lat_ID, Branch_ID, redirect_MEM,
      input  PCWrite, stall_IF_ID, flush_IF_ID, flush_ID_EX, flush_EX_MEM,
             mc_cancel, stall_cycles
   );

   modport slave (
      input  valid_ID, rs1_ID, rs2_ID, rs1_used, rs2_used, rd_ID, RW_ID,
             MemRead_ID, mc_ID, mc_lat_ID, Branch_ID, redirect_MEM,
      output PCWrite, stall_IF_ID, flush_IF_ID, flush_ID_EX, flush_EX_MEM,
             mc_cancel, stall_cycles
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
//  Scoreboard-based hazard unit sitting beside the ID stage. Each register
//  carries a countdown of cycles until its pending result is forwardable;
//  a shared countdown guards the multicycle unit. Produces PC/IF_ID stall,
//  ID_EX bubble and redirect flushes, cancels allocations of the instruction
//  squashed in EX, and counts stalled cycles (saturating).
//  Ports
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  hazard_scoreboard_if.slave (ID request in, hazard controls out)
// ----------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int unsigned NREG      = 32,
   parameter int unsigned AW        = 5,
   parameter int unsigned LOAD_LAT  = 1,
   parameter int unsigned MC_MAXLAT = 31
) (
   input  logic               clk,
   input  logic               rst,
   hazard_scoreboard_if.slave bus
);
   localparam int unsigned CW = $clog2(MC_MAXLAT + 2);

   // Tag of the instruction currently in EX, needed to undo its allocation.
   typedef struct packed {
      logic          v;
      logic [AW-1:0] rd;
      logic          we;
      logic          mc;
   } ex_tag_t;

   logic [CW-1:0] r_cnt [NREG];
   logic [CW-1:0] r_mc_cnt;
   ex_tag_t       r_ex;
   logic [31:0]   r_stall_cycles;

   logic [CW-1:0] w_rs1_cnt;
   logic [CW-1:0] w_rs2_cnt;
   logic          w_rs1_busy;
   logic          w_rs2_busy;
   logic          w_raw;
   logic          w_struct;
   logic          w_stall;
   logic          w_issue;
   logic          w_alloc;
   logic [CW-1:0] w_mc_lat;
   logic [CW-1:0] w_new_cnt;
   logic          w_kill_rd;
   logic          w_kill_mc;

   // Source counter lookup; x0 and out-of-range indices are never busy.
   always_comb begin
      w_rs1_cnt = '0;
      w_rs2_cnt = '0;
      if ((bus.rs1_ID != '0) && (32'(bus.rs1_ID) < NREG))
         w_rs1_cnt = r_cnt[bus.rs1_ID];
      if ((bus.rs2_ID != '0) && (32'(bus.rs2_ID) < NREG))
         w_rs2_cnt = r_cnt[bus.rs2_ID];
   end

   // Branches compare in ID so they need the value one cycle earlier than EX.
   assign w_rs1_busy = bus.Branch_ID ? (w_rs1_cnt != '0) : (w_rs1_cnt > CW'(1));
   assign w_rs2_busy = bus.Branch_ID ? (w_rs2_cnt != '0) : (w_rs2_cnt > CW'(1));

   assign w_raw    = bus.valid_ID & ((bus.rs1_used & w_rs1_busy) |
                                     (bus.rs2_used & w_rs2_busy));
   assign w_struct = bus.valid_ID & bus.mc_ID & (r_mc_cnt != '0);
   assign w_stall  = (w_raw | w_struct) & ~bus.redirect_MEM;
   assign w_issue  = bus.valid_ID & ~w_stall & ~bus.redirect_MEM;
   assign w_alloc  = w_issue & bus.RW_ID & (bus.rd_ID != '0);

   // A zero multicycle latency behaves as a single cycle.
   assign w_mc_lat  = (bus.mc_lat_ID == '0) ? CW'(1) : bus.mc_lat_ID;
   assign w_new_cnt = bus.MemRead_ID ? CW'(1 + LOAD_LAT) :
                      bus.mc_ID      ? (w_mc_lat + CW'(1)) : CW'(1);

   // Redirect squashes the EX instruction: release what it allocated.
   assign w_kill_rd = bus.redirect_MEM & r_ex.v & r_ex.we;
   assign w_kill_mc = bus.redirect_MEM & r_ex.v & r_ex.mc;

   // Per-register countdowns; a new allocation wins over the decrement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++)
            r_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 1; i < NREG; i++) begin
            if (w_kill_rd && (r_ex.rd == AW'(i)))
               r_cnt[i] <= '0;
            else if (w_alloc && (bus.rd_ID == AW'(i)))
               r_cnt[i] <= w_new_cnt;
            else if (r_cnt[i] != '0)
               r_cnt[i] <= r_cnt[i] - CW'(1);
         end
      end
   end

   // Multicycle unit occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_mc_cnt <= '0;
      else if (w_kill_mc)
         r_mc_cnt <= '0;
      else if (w_issue && bus.mc_ID)
         r_mc_cnt <= w_mc_lat;
      else if (r_mc_cnt != '0)
         r_mc_cnt <= r_mc_cnt - CW'(1);
   end

   // EX tag follows the instruction leaving ID (empty when nothing issues).
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ex <= '0;
      else
         r_ex <= '{v: w_issue, rd: bus.rd_ID, we: bus.RW_ID, mc: bus.mc_ID};
   end

   // Saturating stall-cycle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stall_cycles <= '0;
      else if (w_stall && (r_stall_cycles != '1))
         r_stall_cycles <= r_stall_cycles + 32'd1;
   end

   // Pipeline controls; redirect takes priority over any stall.
   always_comb begin
      bus.PCWrite      = 1'b1;
      bus.stall_IF_ID  = 1'b0;
      bus.flush_IF_ID  = 1'b0;
      bus.flush_ID_EX  = 1'b0;
      bus.flush_EX_MEM = 1'b0;
      bus.mc_cancel    = 1'b0;
      if (bus.redirect_MEM) begin
         bus.flush_IF_ID  = 1'b1;
         bus.flush_ID_EX  = 1'b1;
         bus.flush_EX_MEM = 1'b1;
         bus.mc_cancel    = w_kill_mc;
      end else if (w_stall) begin
         bus.PCWrite     = 1'b0;
         bus.stall_IF_ID = 1'b1;
         bus.flush_ID_EX = 1'b1;
      end
   end

   assign bus.stall_cycles = r_stall_cycles;

   a_mc_lat_legal: assert property (@(posedge clk) disable iff (rst)
      (bus.valid_ID && bus.mc_ID) |-> (bus.mc_lat_ID <= CW'(MC_MAXLAT)));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_hazard_scoreboard
//  Directed scenarios against hand-computed stall counts and control values.
//  Inputs change 1 time unit after the rising edge; outputs are sampled
//  mid-cycle.
// ----------------------------------------------------------------------------
module tb_hazard_scoreboard;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   hazard_scoreboard_if #(.AW(5), .MC_MAXLAT(31)) bus ();

   hazard_scoreboard #(.NREG(32), .AW(5), .LOAD_LAT(1), .MC_MAXLAT(31)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic id_set(input bit v, input logic [4:0] rs1, input bit u1,
                         input logic [4:0] rs2, input bit u2, input logic [4:0] rd,
                         input bit rw, input bit ld, input bit mc,
                         input logic [5:0] lat, input bit br);
      bus.valid_ID   = v;
      bus.rs1_ID     = rs1;
      bus.rs1_used   = u1;
      bus.rs2_ID     = rs2;
      bus.rs2_used   = u2;
      bus.rd_ID      = rd;
      bus.RW_ID      = rw;
      bus.MemRead_ID = ld;
      bus.mc_ID      = mc;
      bus.mc_lat_ID  = lat;
      bus.Branch_ID  = br;
   endtask

   task automatic id_idle();
      id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.redirect_MEM = 1'b0;
      id_idle();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Hold the current ID instruction until it issues; n = stalled cycles (-1 on timeout).
   task automatic count_stalls(output int n);
      bit done;
      done = 1'b0;
      n = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         if (bus.stall_IF_ID) n++;
         else done = 1'b1;
         tick();
      end
      if (!done) n = -1;
      id_idle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.redirect_MEM = 1'b0;
      id_idle();
      @(negedge clk);
      n_vec++;
      if (bus.PCWrite !== 1'b1) begin
         n_err++; $display("FAIL reset_pcwrite: got %b want 1", bus.PCWrite);
      end
      n_vec++;
      if ({bus.stall_IF_ID, bus.flush_IF_ID, bus.flush_ID_EX, bus.flush_EX_MEM, bus.mc_cancel} !== 5'b0) begin
         n_err++; $display("FAIL reset_ctrl: got %b want 00000",
            {bus.stall_IF_ID, bus.flush_IF_ID, bus.flush_ID_EX, bus.flush_EX_MEM, bus.mc_cancel});
      end
      n_vec++;
      if (bus.stall_cycles !== 32'd0) begin
         n_err++; $display("FAIL reset_stall_cycles: got %0d want 0", bus.stall_cycles);
      end
      tick();
      rst = 1'b0;
      // mul x9 lat 5, then reader of x9 is stalled; reset mid-op releases it
      id_set(1, 0, 0, 0, 0, 9, 1, 0, 1, 6'd5, 0);
      tick();
      id_set(1, 9, 1, 1, 1, 10, 1, 0, 0, 0, 0);
      @(negedge clk);
      n_vec++;
      if (bus.stall_IF_ID !== 1'b1) begin
         n_err++; $display("FAIL reset_pre_stall: got %b want 1", bus.stall_IF_ID);
      end
      #1 rst = 1'b1;
      #1;
      n_vec++;
      if ({bus.PCWrite, bus.stall_IF_ID, bus.flush_ID_EX} !== 3'b100) begin
         n_err++; $display("FAIL reset_async: got %b want 100",
            {bus.PCWrite, bus.stall_IF_ID, bus.flush_ID_EX});
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.stall_IF_ID !== 1'b0) begin
         n_err++; $display("FAIL reset_dep_issue: got %b want 0", bus.stall_IF_ID);
      end
      n_vec++;
      if (bus.stall_cycles !== 32'd0) begin
         n_err++; $display("FAIL reset_cnt_after: got %0d want 0", bus.stall_cycles);
      end
      id_set(1, 0, 0, 0, 0, 11, 1, 0, 1, 6'd3, 0);
      #1;
      n_vec++;
      if (bus.stall_IF_ID !== 1'b0) begin
         n_err++; $display("FAIL reset_mc_free: got %b want 0", bus.stall_IF_ID);
      end
      tick();
      id_idle();
   endtask

   task automatic test_load_use();
      int n;
      apply_reset();
      id_set(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);          // lw x5
      tick();
      id_set(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0);          // add x6,x5,x1
      #3;
      n_vec++;
      if ({bus.PCWrite, bus.stall_IF_ID, bus.flush_ID_EX, bus.flush_IF_ID} !== 4'b0110) begin
         n_err++; $display("FAIL load_use_ctrl: got %b want 0110",
            {bus.PCWrite, bus.stall_IF_ID, bus.flush_ID_EX, bus.flush_IF_ID});
      end
      count_stalls(n);
      n_vec++;
      if (n !== 1) begin
         n_err++; $display("FAIL load_use_stalls: got %0d want 1", n);
      end
      @(negedge clk);
      n_vec++;
      if (bus.stall_cycles !== 32'd1) begin
         n_err++; $display("FAIL load_use_counter: got %0d want 1", bus.stall_cycles);
      end
      apply_reset();
      id_set(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);          // lw x5
      tick();
      id_set(1, 5, 1, 0, 1, 0, 0, 0, 0, 0, 1);          // beq x5,x0
      count_stalls(n);
      n_vec++;
      if (n !== 2) begin
         n_err++; $display("FAIL load_branch_stalls: got %0d want 2", n);
      end
      @(negedge clk);
      n_vec++;
      if (bus.stall_cycles !== 32'd2) begin
         n_err++; $display("FAIL load_branch_counter: got %0d want 2", bus.stall_cycles);
      end
   endtask

   task automatic test_alu_branch();
      int n;
      apply_reset();
      id_set(1, 1, 1, 0, 0, 7, 1, 0, 0, 0, 0);          // addi x7
      tick();
      id_set(1, 7, 1, 2, 1, 0, 0, 0, 0, 0, 1);          // beq x7,x2
      count_stalls(n);
      n_vec++;
      if (n !== 1) begin
         n_err++; $display("FAIL alu_branch_stalls: got %0d want 1", n);
      end
      apply_reset();
      id_set(1, 1, 1, 0, 0, 7, 1, 0, 0, 0, 0);          // addi x7
      tick();
      id_set(1, 7, 1, 3, 1, 8, 1, 0, 0, 0, 0);          // sub x8,x7,x3
      count_stalls(n);
      n_vec++;
      if (n !== 0) begin
         n_err++; $display("FAIL alu_alu_stalls: got %0d want 0", n);
      end
   endtask

   task automatic test_mc();
      int n;
      apply_reset();
      id_set(1, 1, 1, 2, 1, 9, 1, 0, 1, 6'd4, 0);       // mul x9 lat 4
      tick();
      id_set(1, 9, 1, 1, 1, 10, 1, 0, 0, 0, 0);         // add x10,x9
      count_stalls(n);
      n_vec++;
      if (n !== 4) begin
         n_err++; $display("FAIL mc_raw_stalls: got %0d want 4", n);
      end
      @(negedge clk);
      n_vec++;
      if (bus.stall_cycles !== 32'd4) begin
         n_err++; $display("FAIL mc_raw_counter: got %0d want 4", bus.stall_cycles);
      end
      apply_reset();
      id_set(1, 1, 1, 2, 1, 9, 1, 0, 1, 6'd4, 0);       // mul x9 lat 4
      tick();
      id_set(1, 3, 1, 4, 1, 11, 1, 0, 1, 6'd2, 0);      // mul x11 (structural)
      count_stalls(n);
      n_vec++;
      if (n !== 4) begin
         n_err++; $display("FAIL mc_struct_stalls: got %0d want 4", n);
      end
      apply_reset();
      id_set(1, 1, 1, 2, 1, 12, 1, 0, 1, 6'd0, 0);      // mul x12 lat 0 -> 1
      tick();
      id_set(1, 12, 1, 0, 0, 13, 1, 0, 0, 0, 0);        // add x13,x12
      count_stalls(n);
      n_vec++;
      if (n !== 1) begin
         n_err++; $display("FAIL mc_lat0_stalls: got %0d want 1", n);
      end
   endtask

   task automatic test_cancel();
      apply_reset();
      id_set(1, 1, 1, 2, 1, 9, 1, 0, 1, 6'd4, 0);       // mul x9 lat 4
      tick();
      id_set(1, 9, 1, 1, 1, 10, 1, 0, 0, 0, 0);
      bus.redirect_MEM = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({bus.mc_cancel, bus.flush_IF_ID, bus.flush_ID_EX, bus.flush_EX_MEM,
           bus.PCWrite, bus.stall_IF_ID} !== 6'b111110) begin
         n_err++; $display("FAIL cancel_ctrl: got %b want 111110",
            {bus.mc_cancel, bus.flush_IF_ID, bus.flush_ID_EX, bus.flush_EX_MEM,
             bus.PCWrite, bus.stall_IF_ID});
      end
      tick();
      bus.redirect_MEM = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({bus.stall_IF_ID, bus.mc_cancel} !== 2'b00) begin
         n_err++; $display("FAIL cancel_reader_free: got %b want 00",
            {bus.stall_IF_ID, bus.mc_cancel});
      end
      id_set(1, 0, 0, 0, 0, 11, 1, 0, 1, 6'd3, 0);
      #1;
      n_vec++;
      if (bus.stall_IF_ID !== 1'b0) begin
         n_err++; $display("FAIL cancel_mc_free: got %b want 0", bus.stall_IF_ID);
      end
      n_vec++;
      if (bus.stall_cycles !== 32'd0) begin
         n_err++; $display("FAIL cancel_counter: got %0d want 0", bus.stall_cycles);
      end
      tick();
      id_idle();
   endtask

   task automatic test_redirect_stall();
      apply_reset();
      id_set(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);          // lw x5
      tick();
      id_set(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0);          // add x6,x5 (load-use)
      bus.redirect_MEM = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({bus.PCWrite, bus.stall_IF_ID, bus.flush_IF_ID, bus.flush_ID_EX,
           bus.flush_EX_MEM, bus.mc_cancel} !== 6'b101110) begin
         n_err++; $display("FAIL redir_stall_ctrl: got %b want 101110",
            {bus.PCWrite, bus.stall_IF_ID, bus.flush_IF_ID, bus.flush_ID_EX,
             bus.flush_EX_MEM, bus.mc_cancel});
      end
      tick();
      bus.redirect_MEM = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.stall_cycles !== 32'd0) begin
         n_err++; $display("FAIL redir_stall_counter: got %0d want 0", bus.stall_cycles);
      end
      n_vec++;
      if (bus.stall_IF_ID !== 1'b0) begin
         n_err++; $display("FAIL redir_load_released: got %b want 0", bus.stall_IF_ID);
      end
      tick();
      id_idle();
   endtask

   task automatic test_back_to_back();
      int n;
      apply_reset();
      id_set(1, 1, 1, 2, 1, 5, 1, 0, 1, 6'd4, 0);       // mul x5 lat 4
      tick();
      id_set(1, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0);          // addi x5 overwrites
      tick();
      id_set(1, 5, 1, 2, 1, 6, 1, 0, 0, 0, 0);          // add x6,x5
      count_stalls(n);
      n_vec++;
      if (n !== 0) begin
         n_err++; $display("FAIL waw_overwrite_stalls: got %0d want 0", n);
      end
      apply_reset();
      id_set(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);          // lw x0
      tick();
      id_set(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1);          // beq x0,x0
      count_stalls(n);
      n_vec++;
      if (n !== 0) begin
         n_err++; $display("FAIL x0_never_busy: got %0d want 0", n);
      end
      apply_reset();
      id_set(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);          // lw x5
      tick();
      id_set(1, 5, 0, 5, 0, 6, 1, 0, 0, 0, 0);          // x5 named but not read
      count_stalls(n);
      n_vec++;
      if (n !== 0) begin
         n_err++; $display("FAIL unused_src_stalls: got %0d want 0", n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.redirect_MEM = 1'b0;
      id_idle();
      test_reset();
      test_load_use();
      test_alu_branch();
      test_mc();
      test_cancel();
      test_redirect_stall();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
